// File: rtl/cc_rd_multi_fill_sm.sv
// ---------------------------------------------------------------------------
// cc_rd_multi_fill_sm
//
// Command-response sequencer for a multi-channel readout.  For one command it
// sends the command serial number and command code, then for every selected
// channel (lowest index first) sends that channel's 128-bit header as four
// 32-bit words.  After each header it pops the header FIFO and hands the
// AXIS output over to an external DDR3 reader until that reader's data has
// been drained.  It closes with a 32-bit checksum word.
//
// AXIS handshake: a word is transferred on a rising clk edge where tx_tvalid
// and tx_tready are both high.  Once tx_tvalid is raised, tx_tdata and
// tx_tlast stay constant and tx_tvalid stays high until that transfer
// (the only exception is run_sm low or reset, which abort the command).
//
// Parameters
//   NCHAN  number of header FIFO / fill channels (1..8)
//   TMO_W  width of the DDR3 readout timeout counter
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   run_sm                enable; low returns the machine to IDLE at once
//   chan_mask             channels to read, captured when leaving IDLE
//   csn, cc               command serial number / command code
//   sm_running            high whenever the machine is not in IDLE
//   sm_done               one-cycle pulse on DONE entry
//   sm_error              error flag, cleared when leaving IDLE
//   tx_tdata/tvalid/tlast/tready   response stream
//   hdr_fifo_empty        per-channel header FIFO empty (first-word-fall-through)
//   hdr_fifo_rd_en        one-hot, one-cycle header FIFO pop
//   hdr_fifo_out          channel k header at bits [128k+127:128k]
//   ddr3_rd_start_addr    first DDR3 burst address for the current channel
//   ddr3_rd_burst_cnt     number of DDR3 bursts for the current channel
//   enable_reading        request to the DDR3 reader
//   reading_done          reader complete (asynchronous, synchronised here)
//   use_ddr3_data         output mux selects the DDR3 stream
//   aurora_ddr3_accept    one 32-bit DDR3 word accepted downstream
//
// The current state is held in state_q (type state_e) for observation.
// ---------------------------------------------------------------------------
module cc_rd_multi_fill_sm #(
  parameter int NCHAN = 4,
  parameter int TMO_W = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run_sm,
  input  logic [NCHAN-1:0]     chan_mask,
  input  logic [31:0]          csn,
  input  logic [31:0]          cc,
  output logic                 sm_running,
  output logic                 sm_done,
  output logic                 sm_error,
  output logic [31:0]          tx_tdata,
  output logic                 tx_tvalid,
  output logic                 tx_tlast,
  input  logic                 tx_tready,
  input  logic [NCHAN-1:0]     hdr_fifo_empty,
  output logic [NCHAN-1:0]     hdr_fifo_rd_en,
  input  logic [128*NCHAN-1:0] hdr_fifo_out,
  output logic [22:0]          ddr3_rd_start_addr,
  output logic [21:0]          ddr3_rd_burst_cnt,
  output logic                 enable_reading,
  input  logic                 reading_done,
  output logic                 use_ddr3_data,
  input  logic                 aurora_ddr3_accept
);

  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CHK      = 4'd1,
    S_TX_CSN   = 4'd2,
    S_TX_CC    = 4'd3,
    S_HDR      = 4'd4,
    S_DDR3     = 4'd5,
    S_NEXT     = 4'd6,
    S_TX_CKSUM = 4'd7,
    S_DONE     = 4'd8
  } state_e;

  state_e             state_q;
  logic               running_q;
  logic               done_q;
  logic               err_q;
  logic [31:0]        tdata_q;
  logic               tvalid_q;
  logic               tlast_q;
  logic [NCHAN-1:0]   rd_en_q;
  logic [22:0]        addr_q;
  logic [21:0]        burst_q;
  logic               en_rd_q;
  logic               use_ddr3_q;
  logic [NCHAN-1:0]   mask_q;
  logic [CW-1:0]      chan_q;
  logic [1:0]         word_idx_q;
  logic [23:0]        wcnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [31:0]        cksum_q;
  logic               rd_meta_q;
  logic               rd_sync_q;

  // Two-flop synchroniser for the reader's completion flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_meta_q <= 1'b0;
      rd_sync_q <= 1'b0;
    end else begin
      rd_meta_q <= reading_done;
      rd_sync_q <= rd_meta_q;
    end
  end

  // Channel selection: lowest set channel, and lowest set channel above the
  // current one.  Descending scan so the lowest match is written last.
  logic [CW-1:0] first_ch;
  logic [CW-1:0] next_ch;
  logic          next_found;

  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (mask_q[k]) begin
        first_ch = CW'(k);
      end
      if (mask_q[k] && (k > int'(chan_q))) begin
        next_ch    = CW'(k);
        next_found = 1'b1;
      end
    end
  end

  logic [127:0]     hdr_cur;
  logic [127:0]     hdr_first;
  logic [127:0]     hdr_next;
  logic [1:0]       word_nxt;
  logic [21:0]      burst_new;
  logic [TMO_W-1:0] tmo_inc;
  logic             mask_fail;
  logic [31:0]      cksum_add;

  assign hdr_cur   = hdr_fifo_out[{chan_q, 7'b0} +: 128];
  assign hdr_first = hdr_fifo_out[{first_ch, 7'b0} +: 128];
  assign hdr_next  = hdr_fifo_out[{next_ch, 7'b0} +: 128];
  assign word_nxt  = word_idx_q + 2'd1;
  // 21-bit field zero-extended into 22 bits: the +2 can never wrap.
  assign burst_new = {1'b0, hdr_cur[84:64]} + 22'd2;
  assign tmo_inc   = tmo_q + TMO_W'(1);
  // Every selected FIFO is checked before the first word leaves.
  assign mask_fail = (mask_q == '0) || (|(mask_q & hdr_fifo_empty));
  assign cksum_add = cksum_q + tdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      rd_en_q    <= '0;
      addr_q     <= '0;
      burst_q    <= '0;
      en_rd_q    <= 1'b0;
      use_ddr3_q <= 1'b0;
      mask_q     <= '0;
      chan_q     <= '0;
      word_idx_q <= '0;
      wcnt_q     <= '0;
      tmo_q      <= '0;
      cksum_q    <= '0;
    end else if (!run_sm) begin
      // Abort: nothing in flight completes, no FIFO is popped.
      state_q    <= S_IDLE;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      rd_en_q    <= '0;
      en_rd_q    <= 1'b0;
      use_ddr3_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= '0;
      case (state_q)
        S_IDLE: begin
          running_q <= 1'b1;
          err_q     <= 1'b0;
          mask_q    <= chan_mask;
          cksum_q   <= '0;
          state_q   <= S_CHK;
        end

        S_CHK: begin
          err_q    <= mask_fail;
          tdata_q  <= csn;
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b0;
          state_q  <= S_TX_CSN;
        end

        S_TX_CSN: begin
          if (tx_tready) begin
            cksum_q <= cksum_add;
            tdata_q <= err_q ? ~cc : cc;
            tlast_q <= err_q;
            state_q <= S_TX_CC;
          end
        end

        S_TX_CC: begin
          if (tx_tready) begin
            cksum_q <= cksum_add;
            if (err_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              chan_q     <= first_ch;
              word_idx_q <= 2'd0;
              tdata_q    <= hdr_first[31:0];
              state_q    <= S_HDR;
            end
          end
        end

        S_HDR: begin
          if (tx_tready) begin
            cksum_q <= cksum_add;
            if (word_idx_q != 2'd3) begin
              word_idx_q <= word_nxt;
              tdata_q    <= hdr_cur[{word_nxt, 5'b0} +: 32];
            end else begin
              // Header fully sent: pop it and launch the DDR3 readout.
              rd_en_q[chan_q] <= 1'b1;
              addr_q          <= hdr_cur[57:35];
              burst_q         <= burst_new;
              wcnt_q          <= {burst_new, 2'b00};
              tmo_q           <= '0;
              tvalid_q        <= 1'b0;
              en_rd_q         <= 1'b1;
              use_ddr3_q      <= 1'b1;
              state_q         <= S_DDR3;
            end
          end
        end

        S_DDR3: begin
          tmo_q <= tmo_inc;
          if (aurora_ddr3_accept && (wcnt_q != '0)) begin
            wcnt_q <= wcnt_q - 24'd1;
          end
          if (rd_sync_q && (wcnt_q == '0)) begin
            en_rd_q    <= 1'b0;
            use_ddr3_q <= 1'b0;
            state_q    <= S_NEXT;
          end else if (&tmo_inc) begin
            // Reader stalled: abandon remaining channels, flag it by
            // sending the checksum inverted.
            err_q      <= 1'b1;
            en_rd_q    <= 1'b0;
            use_ddr3_q <= 1'b0;
            tdata_q    <= ~cksum_q;
            tlast_q    <= 1'b1;
            tvalid_q   <= 1'b1;
            state_q    <= S_TX_CKSUM;
          end
        end

        S_NEXT: begin
          // Wait for the reader to drop its done flag before re-arming it.
          if (!rd_sync_q) begin
            tvalid_q <= 1'b1;
            if (next_found) begin
              chan_q     <= next_ch;
              word_idx_q <= 2'd0;
              tdata_q    <= hdr_next[31:0];
              tlast_q    <= 1'b0;
              state_q    <= S_HDR;
            end else begin
              tdata_q <= cksum_q;
              tlast_q <= 1'b1;
              state_q <= S_TX_CKSUM;
            end
          end
        end

        S_TX_CKSUM: begin
          if (tx_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end

        S_DONE: begin
          running_q <= 1'b0;
          state_q   <= S_IDLE;
        end

        default: begin
          running_q <= 1'b0;
          tvalid_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign sm_running         = running_q;
  assign sm_done            = done_q;
  assign sm_error           = err_q;
  assign tx_tdata           = tdata_q;
  assign tx_tvalid          = tvalid_q;
  assign tx_tlast           = tlast_q;
  assign hdr_fifo_rd_en     = rd_en_q;
  assign ddr3_rd_start_addr = addr_q;
  assign ddr3_rd_burst_cnt  = burst_q;
  assign enable_reading     = en_rd_q;
  assign use_ddr3_data      = use_ddr3_q;

endmodule

// File: tb/tb_cc_rd_multi_fill_sm.sv
// ---------------------------------------------------------------------------
// Bench for cc_rd_multi_fill_sm.  A table of command scenarios is applied in
// a loop; each record gives the inputs and hand-derived expectations, and the
// bench builds the expected word stream for the scoreboard.  Hand-written
// sequences cover run_sm abort in a header and reset during a DDR3 readout.
// ---------------------------------------------------------------------------
module tb_cc_rd_multi_fill_sm;
  localparam int NCHAN = 4;
  localparam int TMO_W = 8;

  // ---------------- clock / reset and DUT ----------------
  logic                 clk;
  logic                 reset_n;
  logic                 run_sm;
  logic [NCHAN-1:0]     chan_mask;
  logic [31:0]          csn;
  logic [31:0]          cc;
  logic                 sm_running;
  logic                 sm_done;
  logic                 sm_error;
  logic [31:0]          tx_tdata;
  logic                 tx_tvalid;
  logic                 tx_tlast;
  logic                 tx_tready;
  logic [NCHAN-1:0]     hdr_fifo_empty;
  logic [NCHAN-1:0]     hdr_fifo_rd_en;
  logic [128*NCHAN-1:0] hdr_fifo_out;
  logic [22:0]          ddr3_rd_start_addr;
  logic [21:0]          ddr3_rd_burst_cnt;
  logic                 enable_reading;
  logic                 reading_done;
  logic                 use_ddr3_data;
  logic                 aurora_ddr3_accept;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cc_rd_multi_fill_sm #(.NCHAN(NCHAN), .TMO_W(TMO_W)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .run_sm             (run_sm),
    .chan_mask          (chan_mask),
    .csn                (csn),
    .cc                 (cc),
    .sm_running         (sm_running),
    .sm_done            (sm_done),
    .sm_error           (sm_error),
    .tx_tdata           (tx_tdata),
    .tx_tvalid          (tx_tvalid),
    .tx_tlast           (tx_tlast),
    .tx_tready          (tx_tready),
    .hdr_fifo_empty     (hdr_fifo_empty),
    .hdr_fifo_rd_en     (hdr_fifo_rd_en),
    .hdr_fifo_out       (hdr_fifo_out),
    .ddr3_rd_start_addr (ddr3_rd_start_addr),
    .ddr3_rd_burst_cnt  (ddr3_rd_burst_cnt),
    .enable_reading     (enable_reading),
    .reading_done       (reading_done),
    .use_ddr3_data      (use_ddr3_data),
    .aurora_ddr3_accept (aurora_ddr3_accept)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        got_last_q[$];
  logic [22:0] got_addr_q[$];
  logic [21:0] got_burst_q[$];
  logic [22:0] exp_addr_q[$];
  int          pop_cnt[NCHAN];
  bit          en_seen;
  int          ddr3_cyc;
  bit          prev_en;
  bit          prev_hold;
  logic [31:0] prev_data;
  logic        prev_last;
  bit          stab_en;

  // Driver settings shared with the background responder.
  int tr_mode;     // 0: ready always, 1: ready one cycle in three
  bit reader_en;
  int acc_target;
  int acc_given;
  int cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] make_hdr(input int k, input logic [20:0] b);
    logic [127:0] h;
    h[31:0]   = 32'h1111_0000 + 32'(k);
    h[63:32]  = 32'h2222_0000 + 32'(k * 3);
    h[95:64]  = 32'h3333_0000 + 32'(k * 5);
    h[127:96] = 32'h4444_0000 + 32'(k * 9);
    h[84:64]  = b;
    h[57:35]  = 23'h012345 + 23'(k);
    return h;
  endfunction

  // ---------------- background responder: tready + DDR3 reader ----------------
  initial begin
    tx_tready          = 1'b0;
    reading_done       = 1'b0;
    aurora_ddr3_accept = 1'b0;
    acc_given          = 0;
    cyc                = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_tready = (tr_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (!enable_reading) begin
        aurora_ddr3_accept = 1'b0;
        reading_done       = 1'b0;
        acc_given          = 0;
      end else if (reader_en) begin
        if (acc_given < acc_target) begin
          aurora_ddr3_accept = 1'b1;
          acc_given++;
        end else begin
          aurora_ddr3_accept = 1'b0;
          reading_done       = 1'b1;
        end
      end else begin
        aurora_ddr3_accept = 1'b0;
      end
    end
  end

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (tx_tvalid && tx_tready) begin
      got_q.push_back(tx_tdata);
      got_last_q.push_back(tx_tlast);
    end
    for (int k = 0; k < NCHAN; k++) begin
      if (hdr_fifo_rd_en[k]) pop_cnt[k]++;
    end
    if (enable_reading) begin
      en_seen = 1'b1;
      ddr3_cyc++;
    end
    if (enable_reading && !prev_en) begin
      got_addr_q.push_back(ddr3_rd_start_addr);
      got_burst_q.push_back(ddr3_rd_burst_cnt);
    end
    prev_en = enable_reading;
    if (stab_en && prev_hold) begin
      check("hold_valid", 64'(tx_tvalid), 64'd1);
      check("hold_data", 64'(tx_tdata), 64'(prev_data));
      check("hold_last", 64'(tx_tlast), 64'(prev_last));
    end
    if (stab_en && enable_reading) begin
      check("ddr3_mux", 64'({use_ddr3_data, tx_tvalid}), 64'd2);
    end
    prev_hold = tx_tvalid && !tx_tready;
    prev_data = tx_tdata;
    prev_last = tx_tlast;
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 64'({sm_running, sm_done, sm_error, tx_tvalid, tx_tlast,
                               enable_reading, use_ddr3_data}), 64'd0);
    check({tag, "_tdata"}, 64'(tx_tdata), 64'd0);
    check({tag, "_rd_en"}, 64'(hdr_fifo_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(ddr3_rd_start_addr), 64'd0);
    check({tag, "_burst"}, 64'(ddr3_rd_burst_cnt), 64'd0);
  endtask

  task automatic clear_sb();
    got_q.delete();
    got_last_q.delete();
    got_addr_q.delete();
    got_burst_q.delete();
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < NCHAN; k++) pop_cnt[k] = 0;
    en_seen  = 1'b0;
    ddr3_cyc = 0;
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    logic [NCHAN-1:0] mask;
    logic [NCHAN-1:0] empty;
    logic [20:0]      burst;
    logic [31:0]      csn;
    logic [31:0]      cc;
    int               mode;
    bit               reader;
    bit               exp_err;
    bit               exp_tmo;
    int               exp_words;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input int i, input vec_t v);
    logic [31:0]  sum;
    logic [127:0] h;
    bit           err_m;
    bit           seen;
    bit           err_at_done;
    bit           stop;
    int           first;
    logic [21:0]  exp_burst;

    clear_sb();
    csn            = v.csn;
    cc             = v.cc;
    chan_mask      = v.mask;
    hdr_fifo_empty = v.empty;
    for (int k = 0; k < NCHAN; k++) hdr_fifo_out[128*k +: 128] = make_hdr(k, v.burst);
    tr_mode    = v.mode;
    reader_en  = v.reader;
    exp_burst  = 22'(v.burst) + 22'd2;
    acc_target = int'(exp_burst) * 4;

    // Expected stream straight from the command protocol.
    err_m = (v.mask == '0) || ((v.mask & v.empty) != '0);
    sum   = v.csn;
    exp_q.push_back(v.csn);
    first = -1;
    if (err_m) begin
      exp_q.push_back(~v.cc);
    end else begin
      exp_q.push_back(v.cc);
      sum  = sum + v.cc;
      stop = 1'b0;
      for (int k = 0; k < NCHAN; k++) begin
        if (v.mask[k] && !stop) begin
          if (first < 0) first = k;
          h = make_hdr(k, v.burst);
          for (int w = 0; w < 4; w++) begin
            exp_q.push_back(h[32*w +: 32]);
            sum = sum + h[32*w +: 32];
          end
          exp_addr_q.push_back(23'h012345 + 23'(k));
          if (!v.reader) stop = 1'b1;
        end
      end
      exp_q.push_back(v.reader ? sum : ~sum);
    end

    stab_en = 1'b1;
    @(negedge clk);
    run_sm = 1'b1;
    seen = 1'b0;
    err_at_done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (sm_done) begin
        seen        = 1'b1;
        err_at_done = sm_error;
        break;
      end
    end
    run_sm = 1'b0;
    repeat (2) @(negedge clk);
    stab_en = 1'b0;

    check($sformatf("v%0d_done", i), 64'(seen), 64'd1);
    check($sformatf("v%0d_nwords", i), 64'(got_q.size()), 64'(v.exp_words));
    check($sformatf("v%0d_model_nwords", i), 64'(exp_q.size()), 64'(v.exp_words));
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      check($sformatf("v%0d_word%0d", i, j), 64'(got_q[j]), 64'(exp_q[j]));
      check($sformatf("v%0d_last%0d", i, j), 64'(got_last_q[j]),
            64'(j == exp_q.size() - 1));
    end
    check($sformatf("v%0d_err", i), 64'(err_at_done), 64'(v.exp_err));
    check($sformatf("v%0d_en_seen", i), 64'(en_seen), 64'(!v.exp_err || v.exp_tmo));
    for (int k = 0; k < NCHAN; k++) begin
      check($sformatf("v%0d_pop%0d", i, k), 64'(pop_cnt[k]),
            64'((!err_m && v.mask[k] && (v.reader || k == first)) ? 1 : 0));
    end
    check($sformatf("v%0d_naddr", i), 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
    for (int j = 0; j < got_addr_q.size() && j < exp_addr_q.size(); j++) begin
      check($sformatf("v%0d_addr%0d", i, j), 64'(got_addr_q[j]), 64'(exp_addr_q[j]));
      check($sformatf("v%0d_burst%0d", i, j), 64'(got_burst_q[j]), 64'(exp_burst));
    end
    if (v.exp_tmo) begin
      check($sformatf("v%0d_tmo_cycles", i), 64'(ddr3_cyc), 64'd255);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] h0;
    bit           found;

    reset_n        = 1'b0;
    run_sm         = 1'b0;
    chan_mask      = '0;
    csn            = '0;
    cc             = '0;
    hdr_fifo_empty = '1;
    hdr_fifo_out   = '0;
    tr_mode        = 0;
    reader_en      = 1'b1;
    acc_target     = 0;
    stab_en        = 1'b0;
    prev_en        = 1'b0;
    prev_hold      = 1'b0;
    clear_sb();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_running", 64'(sm_running), 64'd0);

    //         mask     empty    burst  csn           cc            mode rd  err tmo words
    vecs[0] = '{4'b0101, 4'b1010, 21'd3, 32'hC5A0_0001, 32'h0CC0_1234, 0, 1, 0, 0, 11};
    vecs[1] = '{4'b0011, 4'b0010, 21'd3, 32'hC5A0_0002, 32'h0CC0_5678, 0, 1, 1, 0, 2};
    vecs[2] = '{4'b0101, 4'b0000, 21'd3, 32'hC5A0_0001, 32'h0CC0_1234, 1, 1, 0, 0, 11};
    vecs[3] = '{4'b0001, 4'b0000, 21'd3, 32'hC5A0_0004, 32'h0CC0_9ABC, 0, 0, 1, 1, 7};
    vecs[4] = '{4'b1000, 4'b0111, 21'd0, 32'hC5A0_0005, 32'h0CC0_DEF0, 1, 1, 0, 0, 7};
    vecs[5] = '{4'b0000, 4'b0000, 21'd3, 32'hC5A0_0006, 32'hFFFF_0000, 0, 1, 1, 0, 2};
    vecs[6] = '{4'b1111, 4'b0000, 21'd1, 32'hFFFF_FFF0, 32'hFFFF_FF00, 0, 1, 0, 0, 19};

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // ---- run_sm dropped while the second header word is presented ----
    clear_sb();
    tr_mode        = 0;
    reader_en      = 1'b1;
    chan_mask      = 4'b0001;
    hdr_fifo_empty = 4'b0000;
    csn            = 32'hABCD_0001;
    cc             = 32'hABCD_0002;
    for (int k = 0; k < NCHAN; k++) hdr_fifo_out[128*k +: 128] = make_hdr(k, 21'd3);
    h0 = make_hdr(0, 21'd3);
    @(negedge clk);
    run_sm = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (tx_tvalid && (tx_tdata == h0[63:32])) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_hdr1", 64'(found), 64'd1);
    run_sm = 1'b0;
    @(negedge clk);
    check("abort_tvalid", 64'(tx_tvalid), 64'd0);
    check("abort_running", 64'(sm_running), 64'd0);
    check("abort_rd_en", 64'(hdr_fifo_rd_en), 64'd0);
    repeat (4) @(negedge clk);
    check("abort_pops", 64'(pop_cnt[0]), 64'd0);
    check("abort_en_seen", 64'(en_seen), 64'd0);

    // ---- reset asserted during a DDR3 readout ----
    clear_sb();
    @(negedge clk);
    run_sm = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (enable_reading) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reached_ddr3", 64'(found), 64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_zero("rst_ddr3");
    @(negedge clk);
    check("rst_priority_running", 64'(sm_running), 64'd0);
    run_sm  = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cc_rd_multi_fill_sm.md
CC_RD_MULTI_FILL_SM -- requirements
Module: cc_rd_multi_fill_sm

Interface
REQ-001 The block SHALL have these parameters:
- NCHAN, 4, number of header FIFO / fill channels (1..8).
- TMO_W, 24, width of the DDR3 readout timeout counter.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  local clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- run_sm  in  1  run this state machine; low forces IDLE.
- chan_mask  in  NCHAN  channels to read; sampled in IDLE.
- csn  in  32  command serial number.
- cc  in  32  command code.
- sm_running  out  1  high whenever not in IDLE.
- sm_done  out  1  one-cycle pulse on DONE entry.
- sm_error  out  1  error flag; held until next IDLE exit.
- tx_tdata  out  32  response word.
- tx_tvalid  out  1  AXIS valid.
- tx_tlast  out  1  final response word.
- tx_tready  in  1  AXIS ready.
- hdr_fifo_empty  in  NCHAN  per-channel header FIFO empty (FWFT).
- hdr_fifo_rd_en  out  NCHAN  one-hot, one-cycle pop.
- hdr_fifo_out  in  128*NCHAN  channel k at bits [128k+127:128k].
- ddr3_rd_start_addr  out  23  first burst address.
- ddr3_rd_burst_cnt  out  22  bursts to read.
- enable_reading  out  1  request to DDR3 reader.
- reading_done  in  1  asynchronous; reader complete.
- use_ddr3_data  out  1  AXIS mux selects DDR3 stream.
- aurora_ddr3_accept  in  1  one DDR3 32-bit word accepted.

Function
REQ-003 The block SHALL synchronise reading_done through two flops before any use.
REQ-004 The block SHALL use the states IDLE, CHK, TX_CSN, TX_CC, HDR, DDR3, NEXT, TX_CKSUM and DONE.
REQ-005 The block SHALL step through the states as follows:
- IDLE -> CHK when run_sm is high.
- CHK (1 cycle) -> TX_CSN.
- TX_CSN -> TX_CC.
- TX_CC -> DONE on error, else -> HDR for the lowest set channel.
- HDR -> DDR3.
- DDR3 -> NEXT.
- NEXT -> HDR for the next higher set channel, else -> TX_CKSUM.
- TX_CKSUM -> DONE.
- DONE (1 cycle) -> IDLE.
REQ-006 In CHK the block SHALL set error when chan_mask==0 or any masked channel has hdr_fifo_empty high, checking all channels before any word is sent.
REQ-007 Every tx state SHALL hold tx_tvalid high with stable tx_tdata/tx_tlast until a cycle with tx_tready high, then advance.
REQ-008 The block SHALL drive tx_tdata as follows:
- TX_CSN sends csn.
- TX_CC sends cc, or ~cc on error with tx_tlast=1.
- HDR sends four words, header [31:0], [63:32], [95:64], [127:96].
REQ-009 On the handshake of the 4th HDR word, the block SHALL do all of the following for the active channel:
- pulse hdr_fifo_rd_en[k] for one cycle;
- load ddr3_rd_start_addr=hdr[57:35];
- load ddr3_rd_burst_cnt = zero-extended hdr[84:64] + 2, 22 bits, no wrap;
- load a 24-bit word counter = burst_cnt*4.
REQ-010 In DDR3, the block SHALL hold enable_reading and use_ddr3_data high with tx_tvalid low.
REQ-011 In DDR3, the block SHALL decrement the word counter on each aurora_ddr3_accept, saturating at 0.
REQ-012 The block SHALL exit DDR3 when synced reading_done is high and the word counter is 0.
REQ-013 The block SHALL run a TMO_W-bit timeout counter that clears on DDR3 entry and increments each DDR3 cycle.
REQ-014 When the timeout counter reaches all-ones, the block SHALL set sm_error, drop enable_reading/use_ddr3_data and go to TX_CKSUM.
REQ-015 NEXT SHALL hold enable_reading low until synced reading_done is low, for a minimum of 1 cycle.
REQ-016 TX_CKSUM SHALL send the 32-bit modulo-2^32 sum of all words this block transmitted (CSN, CC, header words) with tx_tlast=1, sent inverted when the timeout fired.
REQ-017 run_sm low SHALL force IDLE next cycle and deassert tx_tvalid, enable_reading, use_ddr3_data and hdr_fifo_rd_en, without popping any FIFO.

Reset
REQ-018 While reset_n is low at a clock edge, the block SHALL enter IDLE and clear every output, the error flag and all counters to 0.
REQ-019 Reset SHALL take priority over run_sm.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- mask=4'b0101, both FIFOs full, burst field 3 each, tready always 1 -> CSN, CC, 4 hdr ch0, 20 DDR3 accepts, 4 hdr ch2, 20 accepts, checksum with tlast; one pop per channel.
- mask=4'b0011 with ch1 empty -> CSN, then ~cc with tlast, sm_error=1, no pops, no enable_reading.
- tready toggled 1-of-3 cycles -> tdata stable while valid and not ready; word sequence identical to the first scenario.
- reading_done never asserted, TMO_W=8 -> exit after 255 DDR3 cycles, inverted checksum with tlast, sm_error=1.
- run_sm dropped in the 2nd HDR word -> IDLE next cycle, tvalid low, no pop.
- reset_n low mid-DDR3 -> all outputs 0 next cycle.
